// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state enum, Jump encodings and default PC constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_BR  = 2'b01;
    localparam logic [1:0] JMP_J   = 2'b10;
    localparam logic [1:0] JMP_JR  = 2'b11;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

    // j/jal target: keep the 256 MB region of the delay-free successor
    function automatic logic [31:0] j_target(input logic [3:0]  region,
                                             input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC priority mux: exception, jr, j/jal, taken branch, then sequential.
// Latency: combinational. Backpressure: none; the caller gates with stall.
// FETCH_EPC_EN adds the exception flags used to load epc.
module npc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc,
    input  logic [3:0]  pc_region,
    input  logic [25:0] instr_index,
    input  logic        instr_valid,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        exception,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
`ifdef FETCH_EPC_EN
    output logic        exc_taken,
    output logic        exc_jr,
`endif
    output logic        redirect,
    output logic [31:0] next_pc
);

    logic jr_misalign;
    logic exc_hit;
    logic exc_from_jr;

    assign jr_misalign = (jump == JMP_JR) && (jr_target[1:0] != 2'b00);

    always_comb begin
        next_pc     = pc + 32'd4;
        redirect    = 1'b0;
        exc_hit     = 1'b0;
        exc_from_jr = 1'b0;
        if (instr_valid) begin
            if (exception) begin
                redirect = 1'b1;
                exc_hit  = 1'b1;
                next_pc  = EXC_VECTOR;
            end else if (jump == JMP_JR) begin
                redirect = 1'b1;
                if (jr_misalign) begin
                    exc_hit     = 1'b1;
                    exc_from_jr = 1'b1;
                    next_pc     = EXC_VECTOR;
                end else begin
                    next_pc = jr_target;
                end
            end else if (jump == JMP_J) begin
                redirect = 1'b1;
                next_pc  = j_target(pc_region, instr_index);
            end else if ((jump == JMP_BR) && branch && branch_taken) begin
                redirect = 1'b1;
                next_pc  = branch_target;
            end
        end
    end

`ifdef FETCH_EPC_EN
    assign exc_taken = exc_hit;
    assign exc_jr    = exc_from_jr;
`else
    logic unused_exc;
    assign unused_exc = exc_hit ^ exc_from_jr;
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; FETCH_EPC_EN enables the epc register.
// Latency: one cycle from imem_ready to IF/ID; redirects take effect next edge.
// Backpressure: stall freezes pc and IF/ID; imem_ready=0 re-requests the same address.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        branch_taken,
    input  logic        Exception,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         redirect;
    logic         advance;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (stall) state_nxt = STALL;
            end
            STALL:   if (!stall) state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    assign imem_addr = pc;
    // Redirects are only honoured while the pipeline is moving (stall wins)
    assign advance   = !stall && (state != BOOT);

`ifdef FETCH_EPC_EN
    logic exc_taken;
    logic exc_jr;
`endif

    npc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_npc_sel (
        .pc            (pc),
        .pc_region     (pc_plus4[31:28]),
        .instr_index   (instr[25:0]),
        .instr_valid   (instr_valid),
        .jump          (Jump),
        .branch        (Branch),
        .branch_taken  (branch_taken),
        .exception     (Exception),
        .branch_target (branch_target),
        .jr_target     (jr_target),
`ifdef FETCH_EPC_EN
        .exc_taken     (exc_taken),
        .exc_jr        (exc_jr),
`endif
        .redirect      (redirect),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_plus4    <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                if (redirect) begin
                    // Any word returned this cycle belongs to the wrong path
                    pc          <= next_pc;
                    instr_valid <= 1'b0;
                end else if ((state == FETCH) && imem_ready) begin
                    instr       <= imem_rdata;
                    instr_valid <= 1'b1;
                    pc_plus4    <= pc + 32'd4;
                    pc          <= next_pc;
                end
            end
        end
    end

`ifdef FETCH_EPC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc <= '0;
        end else if (advance && exc_taken) begin
            epc <= exc_jr ? jr_target : (pc_plus4 - 32'd4);
        end
    end
`else
    assign epc = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, imem wait states, jumps, exceptions, stall, wrap, reset.
// Memory model returns address + 0x1000_0000 unless an override word is selected.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  Jump;
    logic        Branch;
    logic        branch_taken;
    logic        Exception;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic [31:0] epc;

    logic        ovr_en;
    logic [31:0] ovr_dat;
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_epc_jr;
    logic [31:0] exp_epc_exc;

    always #5 clk = ~clk;

    assign imem_rdata = ovr_en ? ovr_dat : (imem_addr + 32'h1000_0000);

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .Jump          (Jump),
        .Branch        (Branch),
        .branch_taken  (branch_taken),
        .Exception     (Exception),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_plus4      (pc_plus4),
        .epc           (epc)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FETCH_EPC_EN
        exp_epc_jr  = 32'h0040_0102;
        exp_epc_exc = 32'h8000_0180;
`else
        exp_epc_jr  = 32'h0;
        exp_epc_exc = 32'h0;
`endif
        reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; Jump = 2'b00;
        Branch = 1'b0; branch_taken = 1'b0; Exception = 1'b0;
        branch_target = '0; jr_target = '0; ovr_en = 1'b0; ovr_dat = '0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0040_0000);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_pcp4", pc_plus4, 32'h0);
        check("rst_epc", epc, 32'h0);
        tick();
        reset = 1'b0;
        check("boot_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("f0_req", {31'b0, imem_req}, 32'h1);
        check("f0_addr", imem_addr, 32'h0040_0000);
        tick();
        check("f1_addr", imem_addr, 32'h0040_0004);
        check("f1_instr", instr, 32'h1040_0000);
        check("f1_valid", {31'b0, instr_valid}, 32'h1);
        check("f1_pcp4", pc_plus4, 32'h0040_0004);
        tick();
        check("f2_addr", imem_addr, 32'h0040_0008);
        // three wait-state cycles at 0x00400008
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr", imem_addr, 32'h0040_0008);
            check("wait_valid", {31'b0, instr_valid}, 32'h1);
            check("wait_instr", instr, 32'h1040_0004);
        end
        imem_ready = 1'b1;
        tick();
        check("resume_instr", instr, 32'h1040_0008);
        check("resume_addr", imem_addr, 32'h0040_000C);
        // j with index 0x0100010
        ovr_en = 1'b1; ovr_dat = 32'h0810_0010;
        tick();
        ovr_en = 1'b0;
        check("j_instr", instr, 32'h0810_0010);
        Jump = 2'b10;
        tick();
        Jump = 2'b00;
        check("j_addr", imem_addr, 32'h0040_0040);
        check("j_valid", {31'b0, instr_valid}, 32'h0);
        check("j_discard", instr, 32'h0810_0010);
        tick();
        check("j_fetch", instr, 32'h1040_0040);
        check("j_valid2", {31'b0, instr_valid}, 32'h1);
        // misaligned jr raises an exception
        Jump = 2'b11; jr_target = 32'h0040_0102;
        tick();
        Jump = 2'b00;
        check("jrx_addr", imem_addr, 32'h8000_0180);
        check("jrx_epc", epc, exp_epc_jr);
        tick();
        check("exc_pcp4", pc_plus4, 32'h8000_0184);
        Exception = 1'b1;
        tick();
        Exception = 1'b0;
        check("exc_addr", imem_addr, 32'h8000_0180);
        check("exc_epc", epc, exp_epc_exc);
        tick();
        check("exc_instr", instr, 32'h9000_0180);
        // stall two cycles with a taken branch pending
        stall = 1'b1; Jump = 2'b01; Branch = 1'b1; branch_taken = 1'b1;
        branch_target = 32'h0040_0200;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stl_req", {31'b0, imem_req}, 32'h0);
            check("stl_addr", imem_addr, 32'h8000_0184);
            check("stl_instr", instr, 32'h9000_0180);
            check("stl_valid", {31'b0, instr_valid}, 32'h1);
            check("stl_pcp4", pc_plus4, 32'h8000_0184);
        end
        stall = 1'b0;
        tick();
        Jump = 2'b00; Branch = 1'b0; branch_taken = 1'b0;
        check("br_addr", imem_addr, 32'h0040_0200);
        check("br_req", {31'b0, imem_req}, 32'h1);
        check("br_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("br_instr", instr, 32'h1040_0200);
        // PC wrap from 0xFFFFFFFC
        Jump = 2'b11; jr_target = 32'hFFFF_FFFC;
        tick();
        Jump = 2'b00;
        check("jr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pcp4", pc_plus4, 32'h0);
        check("wrap_instr", instr, 32'h0FFF_FFFC);
        Jump = 2'b11; jr_target = 32'h0040_0010;
        tick();
        Jump = 2'b00;
        check("jr2_addr", imem_addr, 32'h0040_0010);
        // reset while a fetch is outstanding
        imem_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("mrst_req", {31'b0, imem_req}, 32'h0);
        check("mrst_addr", imem_addr, 32'h0040_0000);
        check("mrst_valid", {31'b0, instr_valid}, 32'h0);
        check("mrst_instr", instr, 32'h0);
        check("mrst_epc", epc, 32'h0);
        imem_ready = 1'b1;
        tick();
        check("mrst_hold", instr, 32'h0);
        check("mrst_req2", {31'b0, imem_req}, 32'h0);
        reset = 1'b0;
        check("rboot_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("rf0_req", {31'b0, imem_req}, 32'h1);
        check("rf0_addr", imem_addr, 32'h0040_0000);
        tick();
        check("rf1_instr", instr, 32'h1040_0000);
        check("rf1_addr", imem_addr, 32'h0040_0004);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, 32'h8000_0180, exception handler address.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 imem_req / imem_addr  out  1 / 32  fetch request; word address of the fetch.
REQ-007 imem_ready / imem_rdata  in  1 / 32  fetch complete this cycle; instruction word.
REQ-008 stall  in  1  downstream hold; freeze PC and IF/ID register.
REQ-009 Jump / Branch / branch_taken / Exception  in  2 / 1 / 1 / 1  decoder controls for the IF/ID instruction (Jump: 00 seq, 01 branch, 10 j/jal, 11 jr).
REQ-010 branch_target / jr_target  in  32 / 32  PC-relative target; rs value.
REQ-011 instr / instr_valid / pc_plus4  out  32 / 1 / 32  IF/ID register: word, valid, its address + 4.
REQ-012 epc  out  32  address of last excepting instruction.

Function
REQ-013 States SHALL be BOOT, FETCH and STALL.
REQ-014 BOOT lasts exactly one cycle after reset release, imem_req=0, then goes to FETCH.
REQ-015 In FETCH, imem_req=1 and imem_addr=pc.
REQ-016 FETCH with imem_ready=1 and stall=0 SHALL, next edge: instr<=imem_rdata, instr_valid<=1, pc_plus4<=pc+4, pc<=next_pc.
REQ-017 FETCH with imem_ready=0 SHALL hold pc and leave instr_valid unchanged (re-request same address).
REQ-018 stall=1 SHALL move FETCH to STALL; STALL holds pc, instr, instr_valid, pc_plus4, imem_req=0; stall=0 returns to FETCH.
REQ-019 A redirect is evaluated only when instr_valid=1 and stall=0.
REQ-020 Redirect priority: Exception -> EXC_VECTOR; Jump=11 -> jr_target; Jump=10 -> {pc_plus4[31:28], instr[25:0], 2'b00}; Jump=01 and Branch and branch_taken -> branch_target; else pc+4.
REQ-021 Jump=11 with jr_target[1:0]!=0 SHALL be treated as Exception with epc<=jr_target.
REQ-022 On redirect, next edge: pc<=target, instr_valid<=0; a word returned in the same cycle SHALL be discarded (no delay slot).
REQ-023 Redirect with imem_ready=0 SHALL abandon the pending fetch; imem_addr changes only on redirect while imem_req=1.
REQ-024 On Exception, epc<=pc_plus4-4 (except REQ-021).
REQ-025 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 Stall and redirect together: stall wins, redirect re-evaluated when stall falls.

Reset
REQ-027 Reset SHALL asynchronously force state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, pc_plus4=0, epc=0, imem_req=0.
REQ-028 Reset mid-fetch SHALL drop the outstanding request; imem_ready during reset is ignored.

Configuration
REQ-029 Macro FETCH_EPC_EN: defined -> epc register per REQ-012/024/021; undefined -> no epc register, epc tied 0, exception redirect unchanged.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, Jump encodings (JMP_SEQ, JMP_BR, JMP_J, JMP_JR) and default RESET_PC/EXC_VECTOR constants.
REQ-031 Next-PC priority mux SHALL be a combinational sub-module npc_sel.

Verification
REQ-032 Reset release, imem_ready=1 -> BOOT one cycle, then imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
REQ-033 imem_ready low 3 cycles at 0x00400008 -> imem_addr held, instr_valid unchanged, then advance.
REQ-034 instr=0x0810_0010 valid, Jump=10 -> next imem_addr 0x00400040, instr_valid=0 one cycle.
REQ-035 Jump=11, jr_target=0x00400102 -> imem_addr 0x80000180, epc=0x00400102 (FETCH_EPC_EN); epc=0 without macro.
REQ-036 stall=1 two cycles with Branch, branch_taken=1, branch_target=0x00400200 -> no change while stalled, redirect to 0x00400200 after.
REQ-037 Reset asserted mid-fetch at 0x00400010 -> imem_req=0 immediately, restart at 0x00400000 after BOOT.
